kronos_ex_multicycle: RTL and testbench



---
 rtl/kronos_ex_multicycle_if.sv | 32 +++
 rtl/kronos_ex_multicycle.sv | 143 ++++++++++++++
 tb/tb_kronos_ex_multicycle.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/kronos_ex_multicycle_if.sv
// Stage handshake bundle for the Kronos execute stage: ID-side request and
// WB-side result/forwarding signals. "master" is the ID/WB side, "slave" the stage.
interface kronos_ex_multicycle_if #(
    parameter int XLEN = 32
) ();
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [3:0]      alu_op;
    logic [4:0]      rd_in;
    logic            rd_write_in;
    logic            illegal_in;
    logic            pipe_in_vld;
    logic            pipe_in_rdy;
    logic [XLEN-1:0] result;
    logic [4:0]      rd;
    logic            rd_write;
    logic            illegal;
    logic            pipe_out_vld;
    logic            pipe_out_rdy;
    logic            fwd_vld;
    logic [XLEN-1:0] fwd_data;

    modport master (
        output op1, op2, alu_op, rd_in, rd_write_in, illegal_in, pipe_in_vld, pipe_out_rdy,
        input  pipe_in_rdy, result, rd, rd_write, illegal, pipe_out_vld, fwd_vld, fwd_data
    );

    modport slave (
        input  op1, op2, alu_op, rd_in, rd_write_in, illegal_in, pipe_in_vld, pipe_out_rdy,
        output pipe_in_rdy, result, rd, rd_write, illegal, pipe_out_vld, fwd_vld, fwd_data
    );
endinterface

// File: rtl/kronos_ex_multicycle.sv
// Kronos execute stage: single-cycle ALU/compare ops plus an iterative shifter
// moving up to SHIFT_STEP bit positions per cycle. One result buffer, in order.
module kronos_ex_multicycle #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 4
) (
    input logic                    clk,
    input logic                    rstz,
    kronos_ex_multicycle_if.slave  ex
);
    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [CW:0] STEP = SHIFT_STEP[CW:0];

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLT  = 4'd5,
        OP_SLTU = 4'd6,
        OP_SLL  = 4'd7,
        OP_SRL  = 4'd8,
        OP_SRA  = 4'd9
    } alu_op_e;

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e          state;
    logic [XLEN-1:0] shreg;
    logic [CW-1:0]   cnt;
    logic [3:0]      sh_op;
    logic [XLEN-1:0] result_q;
    logic [4:0]      rd_q;
    logic            rd_write_q;
    logic            illegal_q;
    logic            vld_q;

    logic [XLEN-1:0] alu_res;
    logic            is_shift;
    logic            illegal_op;
    logic [CW-1:0]   shamt;
    logic            start_shift;
    logic            accept;
    logic            consume;
    logic [CW:0]     step;
    logic [CW-1:0]   cnt_next;
    logic [XLEN-1:0] shifted;

    assign shamt       = ex.op2[CW-1:0];
    assign accept      = ex.pipe_in_vld & ex.pipe_in_rdy;
    assign consume     = vld_q & ex.pipe_out_rdy;
    assign start_shift = is_shift & (shamt != '0);

    // Single-cycle result for the offered instruction (shift by 0 passes op1 through).
    always_comb begin
        alu_res    = '0;
        is_shift   = 1'b0;
        illegal_op = 1'b0;
        case (ex.alu_op)
            OP_ADD:  alu_res = ex.op1 + ex.op2;
            OP_SUB:  alu_res = ex.op1 - ex.op2;
            OP_AND:  alu_res = ex.op1 & ex.op2;
            OP_OR:   alu_res = ex.op1 | ex.op2;
            OP_XOR:  alu_res = ex.op1 ^ ex.op2;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(ex.op1) < $signed(ex.op2))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (ex.op1 < ex.op2)};
            OP_SLL, OP_SRL, OP_SRA: begin
                is_shift = 1'b1;
                alu_res  = ex.op1;
            end
            default: illegal_op = 1'b1;
        endcase
    end

    // One shifter iteration: move min(SHIFT_STEP, remaining) positions.
    always_comb begin
        step     = ({1'b0, cnt} < STEP) ? {1'b0, cnt} : STEP;
        cnt_next = cnt - step[CW-1:0];
        shifted  = shreg;
        case (sh_op)
            OP_SLL:  shifted = shreg << step;
            OP_SRA:  shifted = $signed(shreg) >>> step;
            default: shifted = shreg >> step;
        endcase
    end

    // Stage control, shifter iteration and the registered result buffer.
    always_ff @(posedge clk) begin
        if (!rstz) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            sh_op      <= '0;
            result_q   <= '0;
            rd_q       <= '0;
            rd_write_q <= 1'b0;
            illegal_q  <= 1'b0;
            vld_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rd_q       <= ex.rd_in;
                        rd_write_q <= ex.rd_write_in;
                        illegal_q  <= ex.illegal_in | illegal_op;
                        if (start_shift) begin
                            shreg <= ex.op1;
                            cnt   <= shamt;
                            sh_op <= ex.alu_op;
                            vld_q <= 1'b0;
                            state <= SHIFT;
                        end else begin
                            result_q <= alu_res;
                            vld_q    <= 1'b1;
                        end
                    end else if (consume) begin
                        vld_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    shreg <= shifted;
                    cnt   <= cnt_next;
                    if (cnt_next == '0) begin
                        result_q <= shifted;
                        vld_q    <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ex.pipe_in_rdy  = (state == IDLE) & (~vld_q | ex.pipe_out_rdy);
    assign ex.result       = result_q;
    assign ex.rd           = rd_q;
    assign ex.rd_write     = rd_write_q;
    assign ex.illegal      = illegal_q;
    assign ex.pipe_out_vld = vld_q;
    assign ex.fwd_vld      = vld_q & rd_write_q;
    assign ex.fwd_data     = result_q;
endmodule

// File: tb/tb_kronos_ex_multicycle.sv
// Bench for kronos_ex_multicycle: directed vector table, hand-written
// backpressure/reset sequences and randomized ops against a behavioural model.
module tb_kronos_ex_multicycle;
    localparam int XLEN = 32;
    localparam int STEP = 4;

    logic clk = 1'b0;
    logic rstz;
    int   n_pass = 0;
    int   n_total = 0;

    kronos_ex_multicycle_if #(.XLEN(XLEN)) ex ();

    kronos_ex_multicycle #(.XLEN(XLEN), .SHIFT_STEP(STEP)) dut (
        .clk  (clk),
        .rstz (rstz),
        .ex   (ex)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        rdw;
        logic        ill;
        logic [31:0] er;
        logic        eill;
        int          lat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        else n_pass++;
    endtask

    // Reference behaviour: plain arithmetic per op, latency from the shift amount.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ill, output int lat);
        int n;
        n   = int'(b[4:0]);
        ill = 1'b0;
        lat = 1;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: r = (a < b) ? 32'd1 : 32'd0;
            4'd7: r = a << n;
            4'd8: r = a >> n;
            4'd9: r = $signed(a) >>> n;
            default: begin r = 32'd0; ill = 1'b1; end
        endcase
        if (op >= 4'd7 && op <= 4'd9 && n > 0) lat = 1 + (n + STEP - 1) / STEP;
    endfunction

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rdi, input logic rdw, input logic ill);
        ex.alu_op      = op;
        ex.op1         = a;
        ex.op2         = b;
        ex.rd_in       = rdi;
        ex.rd_write_in = rdw;
        ex.illegal_in  = ill;
    endtask

    task automatic drain();
        ex.pipe_in_vld  = 1'b0;
        ex.pipe_out_rdy = 1'b1;
        @(posedge clk); #1;
    endtask

    // Issue one op with WB always ready, measure accept-to-valid latency and check outputs.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rdi, input logic rdw, input logic ill,
                          input logic [31:0] er, input logic eill, input int elat, input string nm);
        int   lat;
        logic rdy_ok;
        chk({nm, " in_rdy"}, {31'd0, ex.pipe_in_rdy}, 32'd1);
        drive(op, a, b, rdi, rdw, ill);
        ex.pipe_in_vld  = 1'b1;
        ex.pipe_out_rdy = 1'b1;
        @(posedge clk); #1;
        ex.pipe_in_vld = 1'b0;
        drive(4'($urandom), $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom));
        lat    = 1;
        rdy_ok = 1'b1;
        while (!ex.pipe_out_vld && lat < 64) begin
            if (ex.pipe_in_rdy) rdy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " latency"}, 32'(lat), 32'(elat));
        chk({nm, " result"}, ex.result, er);
        chk({nm, " fwd_data"}, ex.fwd_data, er);
        chk({nm, " illegal"}, {31'd0, ex.illegal}, {31'd0, eill});
        chk({nm, " rd/rd_write/fwd_vld"}, {25'd0, ex.rd, ex.rd_write, ex.fwd_vld}, {25'd0, rdi, rdw, rdw});
        chk({nm, " in_rdy low during shift"}, {31'd0, rdy_ok}, 32'd1);
    endtask

    vec_t vecs[14];

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b, er;
        logic        ill, eill, hold_ok;
        int          elat;

        rstz = 1'b0;
        ex.pipe_in_vld  = 1'b0;
        ex.pipe_out_rdy = 1'b1;
        drive(4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);

        vecs[0]  = '{4'd0, 32'h7FFF_FFFF, 32'h1,         5'd1,  1'b1, 1'b0, 32'h8000_0000, 1'b0, 1};
        vecs[1]  = '{4'd1, 32'd5,         32'd7,         5'd2,  1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1};
        vecs[2]  = '{4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd3,  1'b1, 1'b0, 32'h0FF0_0FF0, 1'b0, 1};
        vecs[3]  = '{4'd2, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd4,  1'b0, 1'b0, 32'h0F00_0F00, 1'b0, 1};
        vecs[4]  = '{4'd3, 32'h1234_0000, 32'h0000_5678, 5'd5,  1'b1, 1'b0, 32'h1234_5678, 1'b0, 1};
        vecs[5]  = '{4'd5, 32'hFFFF_FFFF, 32'h1,         5'd6,  1'b1, 1'b0, 32'h1,         1'b0, 1};
        vecs[6]  = '{4'd6, 32'hFFFF_FFFF, 32'h1,         5'd7,  1'b1, 1'b0, 32'h0,         1'b0, 1};
        vecs[7]  = '{4'd5, 32'd3,         32'd3,         5'd8,  1'b1, 1'b0, 32'h0,         1'b0, 1};
        vecs[8]  = '{4'd9, 32'h8000_0000, 32'd5,         5'd9,  1'b1, 1'b0, 32'hFC00_0000, 1'b0, 3};
        vecs[9]  = '{4'd8, 32'h8000_0000, 32'd31,        5'd10, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 9};
        vecs[10] = '{4'd7, 32'h1,         32'd0,         5'd11, 1'b1, 1'b0, 32'h1,         1'b0, 1};
        vecs[11] = '{4'd7, 32'h1,         32'h21,        5'd12, 1'b1, 1'b0, 32'h2,         1'b0, 2};
        vecs[12] = '{4'd12, 32'hDEAD_BEEF, 32'h1234_5678, 5'd7, 1'b1, 1'b0, 32'h0,         1'b1, 1};
        vecs[13] = '{4'd0, 32'd1,         32'd2,         5'd13, 1'b0, 1'b1, 32'd3,         1'b1, 1};

        repeat (3) @(posedge clk);
        #1;
        rstz = 1'b1;

        chk("reset pipe_out_vld", {31'd0, ex.pipe_out_vld}, 32'd0);
        chk("reset result", ex.result, 32'd0);
        chk("reset rd/rd_write/illegal/fwd_vld",
            {24'd0, ex.rd, ex.rd_write, ex.illegal, ex.fwd_vld}, 32'd0);
        chk("reset pipe_in_rdy", {31'd0, ex.pipe_in_rdy}, 32'd1);

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].rdw, vecs[i].ill,
                   vecs[i].er, vecs[i].eill, vecs[i].lat, $sformatf("vec%0d", i));

        // Backpressure: hold an AND result, then release with an ADD waiting.
        drain();
        ex.pipe_out_rdy = 1'b0;
        drive(4'd2, 32'hF0F0_F0F0, 32'h3C3C_3C3C, 5'd9, 1'b1, 1'b0);
        ex.pipe_in_vld = 1'b1;
        @(posedge clk); #1;
        drive(4'd0, 32'd10, 32'd20, 5'd3, 1'b1, 1'b0);
        chk("bp and result", ex.result, 32'h3030_3030);
        hold_ok = 1'b1;
        for (int unsigned i = 0; i < 5; i++) begin
            if (ex.result !== 32'h3030_3030 || ex.rd !== 5'd9 || ex.fwd_data !== 32'h3030_3030 ||
                ex.pipe_in_rdy !== 1'b0 || ex.pipe_out_vld !== 1'b1 || ex.fwd_vld !== 1'b1)
                hold_ok = 1'b0;
            @(posedge clk); #1;
        end
        chk("bp outputs held", {31'd0, hold_ok}, 32'd1);
        ex.pipe_out_rdy = 1'b1;
        #1;
        chk("bp in_rdy on release", {31'd0, ex.pipe_in_rdy}, 32'd1);
        @(posedge clk); #1;
        ex.pipe_in_vld = 1'b0;
        chk("bp vld stays", {31'd0, ex.pipe_out_vld}, 32'd1);
        chk("bp add result", ex.result, 32'd30);
        chk("bp add rd", {27'd0, ex.rd}, 32'd3);

        // Reset during the second shift cycle of SRL by 16.
        drive(4'd8, 32'h8000_0000, 32'd16, 5'd4, 1'b1, 1'b0);
        ex.pipe_in_vld = 1'b1;
        @(posedge clk); #1;
        ex.pipe_in_vld = 1'b0;
        @(posedge clk); #1;
        rstz = 1'b0;
        @(posedge clk); #1;
        rstz = 1'b1;
        chk("rst mid-shift vld", {31'd0, ex.pipe_out_vld}, 32'd0);
        chk("rst mid-shift in_rdy", {31'd0, ex.pipe_in_rdy}, 32'd1);
        chk("rst mid-shift result", ex.result, 32'd0);
        hold_ok = 1'b1;
        for (int unsigned i = 0; i < 6; i++) begin
            if (ex.pipe_out_vld !== 1'b0) hold_ok = 1'b0;
            @(posedge clk); #1;
        end
        chk("rst no stray output", {31'd0, hold_ok}, 32'd1);
        run_op(4'd0, 32'd2, 32'd2, 5'd1, 1'b1, 1'b0, 32'd4, 1'b0, 1, "post-reset add");

        // Randomized ops against the model.
        for (int unsigned i = 0; i < 300; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) a = {a[31], 31'($urandom_range(0, 3))};
            ill = ($urandom_range(0, 9) == 0);
            model(op, a, b, er, eill, elat);
            eill = eill | ill;
            run_op(op, a, b, 5'($urandom), 1'($urandom), ill, er, eill, elat, $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
